// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, IF/ID pipeline register, RUN/STALL tracker
// Optional stall/flush counters enabled by macro FETCH_STALL_COUNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int unsigned MAX_STALL    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IF_ID_write,
  input  logic        HazardBit,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic        stall_active,
  output logic        stall_err,
  output logic        proto_err,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [15:0] MAX_STALL_W = 16'(MAX_STALL);

  state_t      state, state_nxt;
  logic [15:0] consec, consec_nxt;
  logic        stall_cycle;
  logic        proto_seen;
  logic [31:0] pc_plus4;

  assign stall_cycle  = !branch_taken && !PCWrite;
  // The hazard unit must drive PCWrite/IF_ID_write together and HazardBit as their inverse.
  assign proto_seen   = !branch_taken && ((PCWrite != IF_ID_write) || (HazardBit != !PCWrite));
  assign pc_plus4     = pc + 32'd4;
  assign stall_active = (state == STALL);

  always_comb begin
    state_nxt  = state;
    consec_nxt = consec;
    case (state)
      RUN: begin
        if (stall_cycle) begin
          state_nxt  = STALL;
          consec_nxt = 16'd1;
        end else begin
          consec_nxt = 16'd0;
        end
      end
      STALL: begin
        if (stall_cycle) begin
          if (consec != 16'hFFFF) consec_nxt = consec + 16'd1;
        end else begin
          state_nxt  = RUN;
          consec_nxt = 16'd0;
        end
      end
      default: begin
        state_nxt  = RUN;
        consec_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      consec      <= 16'd0;
      pc          <= RESET_VECTOR;
      IF_ID_pc4   <= 32'd0;
      IF_ID_instr <= 32'd0;
      IF_ID_valid <= 1'b0;
      stall_err   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      consec <= consec_nxt;
      if (stall_cycle && (consec == MAX_STALL_W)) stall_err <= 1'b1;
      if (proto_seen) proto_err <= 1'b1;
      if (branch_taken) begin
        pc          <= branch_target;
        IF_ID_pc4   <= 32'd0;
        IF_ID_instr <= 32'd0;
        IF_ID_valid <= 1'b0;
      end else begin
        if (PCWrite) pc <= pc_plus4;
        if (IF_ID_write) begin
          IF_ID_pc4   <= pc_plus4;
          IF_ID_instr <= instr_in;
          IF_ID_valid <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (stall_cycle && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (branch_taken && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign stall_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;

  localparam logic [31:0] RV = 32'h00000000;
  localparam int          MS = 1;

  logic        clk = 1'b0;
  logic        rst_n, PCWrite, IF_ID_write, HazardBit, branch_taken;
  logic [31:0] branch_target, instr_in;
  logic [31:0] pc, IF_ID_pc4, IF_ID_instr;
  logic        IF_ID_valid, stall_active, stall_err, proto_err;
  logic [15:0] stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_in_stall, m_serr, m_perr;
  int          m_consec;
  int          m_scnt, m_fcnt;

  fetch_stage #(.RESET_VECTOR(RV), .MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_write(IF_ID_write),
    .HazardBit(HazardBit), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_in(instr_in), .pc(pc), .IF_ID_pc4(IF_ID_pc4), .IF_ID_instr(IF_ID_instr),
    .IF_ID_valid(IF_ID_valid), .stall_active(stall_active), .stall_err(stall_err),
    .proto_err(proto_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt(input int v);
`ifdef FETCH_STALL_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Drives one cycle of inputs, advances the model by the spec rules, samples 1ns after the edge.
  task automatic apply(input logic rst, input logic pw, input logic iw, input logic hz,
                       input logic bt, input logic [31:0] tgt, input logic [31:0] ins);
    logic stall;
    rst_n = rst; PCWrite = pw; IF_ID_write = iw; HazardBit = hz;
    branch_taken = bt; branch_target = tgt; instr_in = ins;
    @(posedge clk);
    if (!rst) begin
      m_pc = RV; m_pc4 = 0; m_instr = 0; m_valid = 0;
      m_in_stall = 0; m_consec = 0; m_serr = 0; m_perr = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      stall = !bt && !pw;
      if (!bt && (pw != iw || hz == pw)) m_perr = 1;
      if (stall && m_consec == MS) m_serr = 1;
      if (bt) begin
        m_pc = tgt; m_pc4 = 0; m_instr = 0; m_valid = 0;
        if (m_fcnt < 65535) m_fcnt++;
      end else begin
        if (iw) begin m_instr = ins; m_pc4 = m_pc + 32'd4; m_valid = 1; end
        if (pw) m_pc = m_pc + 32'd4;
      end
      if (stall) begin
        if (m_scnt < 65535) m_scnt++;
        m_consec = m_in_stall ? ((m_consec < 65535) ? m_consec + 1 : m_consec) : 1;
        m_in_stall = 1;
      end else begin
        m_in_stall = 0;
        m_consec = 0;
      end
    end
    #1;
  endtask

  task automatic run(input logic [31:0] ins);
    apply(1, 1, 1, 0, 0, 32'h0, ins);
  endtask

  task automatic stall1();
    apply(1, 0, 0, 1, 0, 32'h0, $urandom);
  endtask

  task automatic test_reset();
    apply(0, 1, 1, 0, 1, 32'hDEADBEEC, 32'h12345678);
    vectors++; if (pc !== RV) begin miscompares++; $display("FAIL rst_pc got=%h exp=%h", pc, RV); end
    vectors++; if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== 65'd0) begin miscompares++; $display("FAIL rst_ifid got=%h/%h/%b exp=0", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
    vectors++; if ({stall_active, stall_err, proto_err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got=%b exp=000", {stall_active, stall_err, proto_err}); end
    vectors++; if ({stall_count, flush_count} !== 32'd0) begin miscompares++; $display("FAIL rst_counts got=%h/%h exp=0", stall_count, flush_count); end
  endtask

  task automatic test_free_run();
    logic [31:0] ins;
    apply(0, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      ins = $urandom;
      run(ins);
      vectors++; if (pc !== 32'(4 * i)) begin miscompares++; $display("FAIL fr_pc got=%h exp=%h", pc, 32'(4 * i)); end
      vectors++; if (IF_ID_pc4 !== 32'(4 * i) || IF_ID_valid !== 1'b1 || IF_ID_instr !== ins) begin
        miscompares++; $display("FAIL fr_ifid got=%h/%b/%h exp=%h/1/%h", IF_ID_pc4, IF_ID_valid, IF_ID_instr, 32'(4 * i), ins); end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] held;
    apply(0, 1, 1, 0, 0, 0, 0);
    run($urandom); run($urandom);
    held = IF_ID_instr;
    stall1();
    vectors++; if (pc !== 32'h8 || IF_ID_pc4 !== 32'h8 || IF_ID_instr !== held) begin miscompares++; $display("FAIL lu_hold got=%h/%h/%h exp=8/8/%h", pc, IF_ID_pc4, IF_ID_instr, held); end
    vectors++; if (stall_active !== 1'b1 || stall_err !== 1'b0) begin miscompares++; $display("FAIL lu_flags got=%b%b exp=10", stall_active, stall_err); end
    vectors++; if (stall_count !== 16'(exp_cnt(1))) begin miscompares++; $display("FAIL lu_scnt got=%0d exp=%0d", stall_count, exp_cnt(1)); end
    run($urandom);
    vectors++; if (stall_active !== 1'b0 || pc !== 32'hC) begin miscompares++; $display("FAIL lu_resume got=%b/%h exp=0/c", stall_active, pc); end
  endtask

  task automatic test_flush_in_stall();
    apply(0, 1, 1, 0, 0, 0, 0);
    run($urandom); run($urandom);
    stall1();
    apply(1, 0, 0, 1, 1, 32'h100, $urandom);
    vectors++; if (pc !== 32'h100 || IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0 || IF_ID_pc4 !== 32'h0) begin
      miscompares++; $display("FAIL fl_state got=%h/%b/%h/%h exp=100/0/0/0", pc, IF_ID_valid, IF_ID_instr, IF_ID_pc4); end
    vectors++; if (stall_active !== 1'b0) begin miscompares++; $display("FAIL fl_run got=%b exp=0", stall_active); end
    vectors++; if (flush_count !== 16'(exp_cnt(1))) begin miscompares++; $display("FAIL fl_fcnt got=%0d exp=%0d", flush_count, exp_cnt(1)); end
  endtask

  task automatic test_overstall();
    apply(0, 1, 1, 0, 0, 0, 0);
    stall1();
    vectors++; if (stall_err !== 1'b0) begin miscompares++; $display("FAIL os_first got=%b exp=0", stall_err); end
    stall1();
    vectors++; if (stall_err !== 1'b1) begin miscompares++; $display("FAIL os_second got=%b exp=1", stall_err); end
    run($urandom); run($urandom);
    vectors++; if (stall_err !== 1'b1) begin miscompares++; $display("FAIL os_sticky got=%b exp=1", stall_err); end
    vectors++; if (stall_count !== 16'(exp_cnt(2))) begin miscompares++; $display("FAIL os_scnt got=%0d exp=%0d", stall_count, exp_cnt(2)); end
  endtask

  task automatic test_proto_err();
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 32'hCAFEF00D);
    vectors++; if (proto_err !== 1'b1 || pc !== 32'h4 || IF_ID_valid !== 1'b0) begin
      miscompares++; $display("FAIL pe_set got=%b/%h/%b exp=1/4/0", proto_err, pc, IF_ID_valid); end
    run($urandom);
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL pe_sticky got=%b exp=1", proto_err); end
    apply(0, 1, 1, 0, 0, 0, 0);
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL pe_clear got=%b exp=0", proto_err); end
  endtask

  task automatic test_wrap_and_reset();
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 1, 1, 32'hFFFFFFFC, 0);
    run(32'h11111111);
    vectors++; if (pc !== 32'h0 || IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1'b1) begin
      miscompares++; $display("FAIL wrap got=%h/%h/%b exp=0/0/1", pc, IF_ID_pc4, IF_ID_valid); end
    run($urandom); stall1();
    vectors++; if (stall_active !== 1'b1) begin miscompares++; $display("FAIL mr_install got=%b exp=1", stall_active); end
    apply(0, 0, 0, 1, 1, 32'h500, 0);
    vectors++; if (pc !== RV || stall_active !== 1'b0 || stall_count !== 16'd0) begin
      miscompares++; $display("FAIL mr_reset got=%h/%b/%0d exp=%h/0/0", pc, stall_active, stall_count, RV); end
  endtask

  task automatic test_random();
    logic pw, iw, hz, bt, rst;
    apply(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) >= 3);
      bt  = ($urandom_range(0, 99) < 12);
      pw  = ($urandom_range(0, 99) < 65);
      iw  = ($urandom_range(0, 99) < 8) ? !pw : pw;
      hz  = ($urandom_range(0, 99) < 8) ? pw : !pw;
      apply(rst, pw, iw, hz, bt, {$urandom} & 32'hFFFFFFFC, $urandom);
      vectors++;
      if (pc !== m_pc || IF_ID_pc4 !== m_pc4 || IF_ID_instr !== m_instr || IF_ID_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rnd_data i=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", i, pc, IF_ID_pc4, IF_ID_instr, IF_ID_valid, m_pc, m_pc4, m_instr, m_valid);
      end
      vectors++;
      if (stall_active !== m_in_stall || stall_err !== m_serr || proto_err !== m_perr ||
          stall_count !== 16'(exp_cnt(m_scnt)) || flush_count !== 16'(exp_cnt(m_fcnt))) begin
        miscompares++;
        $display("FAIL rnd_ctrl i=%0d got=%b%b%b/%0d/%0d exp=%b%b%b/%0d/%0d", i, stall_active, stall_err, proto_err,
                 stall_count, flush_count, m_in_stall, m_serr, m_perr, exp_cnt(m_scnt), exp_cnt(m_fcnt));
      end
    end
  endtask

  initial begin
    rst_n = 0; PCWrite = 1; IF_ID_write = 1; HazardBit = 0;
    branch_taken = 0; branch_target = 0; instr_in = 0;
    #1;
    test_reset();
    test_free_run();
    test_load_use();
    test_flush_in_stall();
    test_overstall();
    test_proto_err();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
